pc_btb_stage: RTL

Parametrised next-generation program counter stage for the RISC-V pipeline. It holds the fetch PC and predicts the next PC using a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters. It resolves JAL, JALR and conditional branches that arrive from the execute stage and raises a redirect on any misprediction. It detects both wrong-taken and wrong-not-taken predictions, and trains itself from execute-stage outcomes.

---
 rtl/pc_btb_stage.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pc_btb_stage.sv
// Fetch PC stage with a direct-mapped BTB and saturating direction counters.
// Resolves control flow from execute, redirects on misprediction and trains the BTB.
module pc_btb_stage #(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         DATA_WIDTH    = 32,
  parameter int                         ALU_INS_WIDTH = 5,
  parameter logic [ALU_INS_WIDTH-1:0]   ALU_JAL       = 5'b01110,
  parameter logic [ALU_INS_WIDTH-1:0]   ALU_JALR      = 5'b01111,
  parameter int                         BTB_DEPTH     = 16,
  parameter int                         COUNTER_WIDTH = 2,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = 32'h0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     STALL_PROGRAME_COUNTER_STAGE,
  input  logic                     EX_VALID,
  input  logic                     BRANCH_INST,
  input  logic [ALU_INS_WIDTH-1:0] ALU_INSTRUCTION,
  input  logic                     BRANCH_TAKEN,
  input  logic [ADDRESS_WIDTH-1:0] PC_EXECUTION,
  input  logic [DATA_WIDTH-1:0]    RS1_DATA,
  input  logic [DATA_WIDTH-1:0]    IMM_INPUT,
  input  logic [ADDRESS_WIDTH-1:0] PC_DECODING,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic                     PC_VALID,
  output logic                     PC_MISPREDICT_SELECT,
  output logic                     PC_PREDICTED_TAKEN
);

  localparam int IDX   = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDRESS_WIDTH - IDX - 2;
  localparam logic [COUNTER_WIDTH-1:0] CTR_MAX  = {COUNTER_WIDTH{1'b1}};
  localparam logic [COUNTER_WIDTH-1:0] CTR_WEAK = COUNTER_WIDTH'(1 << (COUNTER_WIDTH - 1));

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic                     pc_valid_q;

  logic [BTB_DEPTH-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]         tag_q    [BTB_DEPTH];
  logic [TAG_W-1:0]         tag_d    [BTB_DEPTH];
  logic [ADDRESS_WIDTH-1:0] target_q [BTB_DEPTH];
  logic [ADDRESS_WIDTH-1:0] target_d [BTB_DEPTH];
  logic [COUNTER_WIDTH-1:0] ctr_q    [BTB_DEPTH];
  logic [COUNTER_WIDTH-1:0] ctr_d    [BTB_DEPTH];

  logic                     is_jal, is_jalr, is_cf, taken, mispredict;
  logic [ADDRESS_WIDTH-1:0] base, target_sum, target, resolved;
  logic [IDX-1:0]           idx_f, idx_x;
  logic [TAG_W-1:0]         tag_f, tag_x;
  logic                     hit_f, hit_x, predicted_taken;

  // Resolution of the instruction currently in execute.
  always_comb begin
    is_jal     = (ALU_INSTRUCTION == ALU_JAL);
    is_jalr    = (ALU_INSTRUCTION == ALU_JALR);
    base       = is_jalr ? ADDRESS_WIDTH'(RS1_DATA) : PC_EXECUTION;
    target_sum = base + ADDRESS_WIDTH'($signed(IMM_INPUT));
    target     = is_jalr ? {target_sum[ADDRESS_WIDTH-1:1], 1'b0} : target_sum;
    is_cf      = EX_VALID & (BRANCH_INST | is_jal | is_jalr);
    taken      = is_jal | is_jalr | (BRANCH_INST & BRANCH_TAKEN);
    resolved   = taken ? target : PC_EXECUTION + ADDRESS_WIDTH'(4);
    mispredict = is_cf & (resolved != PC_DECODING);
  end

  always_comb begin
    idx_f           = pc_q[IDX+1:2];
    tag_f           = pc_q[ADDRESS_WIDTH-1:IDX+2];
    hit_f           = valid_q[idx_f] & (tag_q[idx_f] == tag_f);
    predicted_taken = hit_f & ctr_q[idx_f][COUNTER_WIDTH-1];
    idx_x           = PC_EXECUTION[IDX+1:2];
    tag_x           = PC_EXECUTION[ADDRESS_WIDTH-1:IDX+2];
    hit_x           = valid_q[idx_x] & (tag_q[idx_x] == tag_x);
  end

  // A redirect wins over a stall so the flushed path is never refetched.
  always_comb begin
    if (mispredict)                        pc_d = resolved;
    else if (STALL_PROGRAME_COUNTER_STAGE) pc_d = pc_q;
    else if (predicted_taken)              pc_d = target_q[idx_f];
    else                                   pc_d = pc_q + ADDRESS_WIDTH'(4);
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (is_cf) begin
      if (hit_x) begin
        if (taken) begin
          target_d[idx_x] = target;
          if (ctr_q[idx_x] != CTR_MAX) ctr_d[idx_x] = ctr_q[idx_x] + COUNTER_WIDTH'(1);
        end else if (ctr_q[idx_x] != '0) begin
          ctr_d[idx_x] = ctr_q[idx_x] - COUNTER_WIDTH'(1);
        end
      end else if (taken) begin
        valid_d[idx_x]  = 1'b1;
        tag_d[idx_x]    = tag_x;
        target_d[idx_x] = target;
        ctr_d[idx_x]    = (is_jal | is_jalr) ? CTR_MAX : CTR_WEAK;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= 1'b1;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      target_q   <= target_d;
      ctr_q      <= ctr_d;
    end
  end

  assign PC                   = pc_q;
  assign PC_VALID             = pc_valid_q;
  assign PC_MISPREDICT_SELECT = mispredict;
  assign PC_PREDICTED_TAKEN   = predicted_taken;

endmodule
